// File: rtl/nes_pkg.sv
// nes_pkg: shared scan states, button bit positions and register offsets for the NES pad reader.
package nes_pkg;
    typedef enum logic [2:0] {IDLE, LATCH, SETTLE, PULSE, DONE} scan_state_t;
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam logic [7:0] REG_SERIAL = 8'd0;
    localparam logic [7:0] REG_SNAP   = 8'd1;
    localparam logic [7:0] REG_STAT   = 8'd2;
endpackage

// File: rtl/nes_pad_scanner.sv
// nes_pad_scanner: free-running joypad scan FSM driving latch/clock pins and capturing 8 button bits.
module nes_pad_scanner
    import nes_pkg::*;
#(
    parameter int CLK_DIV     = 6,
    parameter int POLL_PERIOD = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic       busy,
    output logic       commit,
    output logic [7:0] work,
    output logic [7:0] snapshot
);
    localparam int PW = $clog2(POLL_PERIOD);
    localparam int DW = $clog2(2 * CLK_DIV);
    localparam logic [PW-1:0] POLL_END  = PW'(POLL_PERIOD - 1);
    localparam logic [DW-1:0] LATCH_END = DW'(2 * CLK_DIV - 1);
    localparam logic [DW-1:0] PHASE_END = DW'(CLK_DIV - 1);

    scan_state_t   state, state_nxt;
    logic [PW-1:0] poll_cnt;
    logic [DW-1:0] div_cnt;
    logic [2:0]    idx;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (poll_cnt == POLL_END) state_nxt = LATCH;
            LATCH:   if (div_cnt == LATCH_END) state_nxt = SETTLE;
            SETTLE:  if (div_cnt == PHASE_END) state_nxt = (idx == 3'd7) ? DONE : PULSE;
            PULSE:   if (div_cnt == PHASE_END) state_nxt = SETTLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pad_latch = state == LATCH;
        pad_clk   = state == PULSE;
        busy      = state != IDLE;
        commit    = state == DONE;
    end

    // The divider restarts on every state change so each phase gets its full width.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            poll_cnt <= '0;
            div_cnt  <= '0;
            idx      <= '0;
            work     <= '0;
            snapshot <= '0;
        end else begin
            poll_cnt <= (state == IDLE && poll_cnt != POLL_END) ? poll_cnt + 1'b1 : '0;
            div_cnt  <= (state != state_nxt || state == IDLE || state == DONE) ? '0 : div_cnt + 1'b1;
            if (state == LATCH)
                idx <= '0;
            else if (state == PULSE && state_nxt == SETTLE)
                idx <= idx + 3'd1;
            if (state == SETTLE && div_cnt == PHASE_END)
                work[idx] <= ~pad_data;
            if (state == DONE)
                snapshot <= work;
        end
endmodule

// File: rtl/nes_pad_reader.sv
// nes_pad_reader: bus responder exposing the NES pad as a $4016-style serial port,
// a parallel snapshot and a status register.
module nes_pad_reader
    import nes_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR   = 8'h16,
    parameter int         CLK_DIV     = 6,
    parameter int         POLL_PERIOD = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] bus_addr,
    input  logic [7:0] bus_wdata,
    input  logic       bus_we,
    input  logic       bus_re,
    output logic [7:0] bus_rdata,
    output logic       bus_rvalid,
    output logic       pad_latch,
    output logic       pad_clk,
    input  logic       pad_data
);
    logic       busy, commit, strobe, new_data;
    logic [7:0] work, snapshot, shift, snap_now, rdata_nxt;
    logic       sel_serial, sel_snap, sel_stat, mapped, wr_serial, rd_serial;
    logic       unused_wdata;

    nes_pad_scanner #(.CLK_DIV(CLK_DIV), .POLL_PERIOD(POLL_PERIOD)) u_scanner (
        .clk(clk),
        .rst_n(rst_n),
        .pad_data(pad_data),
        .pad_latch(pad_latch),
        .pad_clk(pad_clk),
        .busy(busy),
        .commit(commit),
        .work(work),
        .snapshot(snapshot)
    );

    assign unused_wdata = ^bus_wdata[7:1];
    assign sel_serial   = bus_addr == BASE_ADDR + REG_SERIAL;
    assign sel_snap     = bus_addr == BASE_ADDR + REG_SNAP;
    assign sel_stat     = bus_addr == BASE_ADDR + REG_STAT;
    assign mapped       = sel_serial | sel_snap | sel_stat;
    assign wr_serial    = bus_we & sel_serial;
    assign rd_serial    = bus_re & sel_serial;
    // A strobed shift register must see a snapshot being committed this very cycle.
    assign snap_now     = commit ? work : snapshot;

    always_comb
        rdata_nxt = sel_serial ? {7'b0, shift[0]} : sel_snap ? snapshot : {6'b0, new_data, busy};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bus_rdata  <= '0;
            bus_rvalid <= 1'b0;
            strobe     <= 1'b0;
            shift      <= '0;
            new_data   <= 1'b0;
        end else begin
            bus_rvalid <= bus_re & mapped;
            if (bus_re && mapped)
                bus_rdata <= rdata_nxt;
            if (wr_serial)
                strobe <= bus_wdata[0];
            if (strobe || (wr_serial && bus_wdata[0]))
                shift <= snap_now;
            else if (rd_serial)
                shift <= {1'b1, shift[7:1]};
            if (commit)
                new_data <= 1'b1;
            else if (bus_re && sel_stat)
                new_data <= 1'b0;
        end
endmodule
